// File: rtl/basic_cpu_pkg.sv
// Shared definitions for the basic computer: widths, opcodes, execution-stage states.
package basic_cpu_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_IND_RD  = 3'd1;
  localparam state_t ST_IND_CAP = 3'd2;
  localparam state_t ST_RD      = 3'd3;
  localparam state_t ST_EXEC    = 3'd4;
  localparam state_t ST_WR      = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  // First state after the effective address is known.
  function automatic state_t dispatch(input logic [2:0] op);
    state_t st;
    case (op)
      OP_AND, OP_ADD, OP_LDA, OP_ISZ: st = ST_RD;
      OP_STA, OP_BSA:                 st = ST_WR;
      default:                        st = ST_DONE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mri_alu.sv
// Combinational datapath for memory-reference instructions: AND, 17-bit ADD, increment, zero-detect.
module mri_alu #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] dr_i,
  output logic [DW-1:0] and_o,
  output logic [DW:0]   sum_o,
  output logic [DW-1:0] inc_o,
  output logic          zero_o
);

  assign and_o  = a_i & b_i;
  assign sum_o  = {1'b0, a_i} + {1'b0, b_i};
  assign inc_o  = b_i + {{(DW-1){1'b0}}, 1'b1};
  assign zero_o = (dr_i == {DW{1'b0}});

endmodule

// File: rtl/mem_ref_exec.sv
// Memory-reference execution stage (AND/ADD/LDA/STA/BUN/BSA/ISZ) against a synchronous SRAM.
// Define INDIRECT_EN to honour the indirect-address bit (adds IND_RD/IND_CAP states).
module mem_ref_exec
  import basic_cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    opcode,
  input  logic          ind,
  input  logic [AW-1:0] ar_in,
  input  logic [DW-1:0] ac_in,
  input  logic          e_in,
  input  logic [AW-1:0] pc_in,
  input  logic [DW-1:0] sram_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  output logic          sram_we,
  output logic [DW-1:0] ac_out,
  output logic          e_out,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic          done,
  output logic          illegal
);

  state_t        state_q, state_d;
  logic [2:0]    opc_q, opc_d;
  logic [AW-1:0] ar_q, ar_d, pc_q, pc_d, pc_out_q, pc_out_d;
  logic [DW-1:0] ac_q, ac_d, dr_q, dr_d, ac_out_q, ac_out_d;
  logic          e_q, e_d, e_out_q, e_out_d;
  logic          busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;

  logic [DW-1:0] and_s, inc_s;
  logic [DW:0]   sum_s;
  logic          dr_zero_s;

`ifndef INDIRECT_EN
  logic ind_unused_s;
  assign ind_unused_s = ind;
`endif

  mri_alu #(.DW(DW)) u_alu (
    .a_i   (ac_q),
    .b_i   (sram_rdata),
    .dr_i  (dr_q),
    .and_o (and_s),
    .sum_o (sum_s),
    .inc_o (inc_s),
    .zero_o(dr_zero_s)
  );

  // Next-state and datapath update for the execution FSM.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    ar_d      = ar_q;
    ac_d      = ac_q;
    e_d       = e_q;
    pc_d      = pc_q;
    dr_d      = dr_q;
    ac_out_d  = ac_out_q;
    e_out_d   = e_out_q;
    pc_out_d  = pc_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opc_d  = opcode;
          ar_d   = ar_in;
          ac_d   = ac_in;
          e_d    = e_in;
          pc_d   = pc_in;
          busy_d = 1'b1;
`ifdef INDIRECT_EN
          if (ind) begin
            state_d = ST_IND_RD;
          end else begin
            state_d = dispatch(opcode);
          end
`else
          state_d = dispatch(opcode);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef INDIRECT_EN
      ST_IND_RD:  state_d = ST_IND_CAP;
      ST_IND_CAP: begin
        ar_d    = sram_rdata[AW-1:0];
        state_d = dispatch(opc_q);
      end
`endif
      ST_RD: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_DONE;
        case (opc_q)
          OP_AND:  ac_d = and_s;
          OP_ADD:  {e_d, ac_d} = sum_s;
          OP_LDA:  ac_d = sram_rdata;
          OP_ISZ: begin
            dr_d    = inc_s;
            state_d = ST_WR;
          end
          default: state_d = ST_DONE;
        endcase
      end
      ST_WR: begin
        state_d = ST_DONE;
        if (opc_q == OP_BSA) begin
          pc_d = ar_q + {{(AW-1){1'b0}}, 1'b1};
        end else if (opc_q == OP_ISZ && dr_zero_s) begin
          pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          pc_d = pc_q;
        end
      end
      ST_DONE: begin
        // BUN resolves here so an indirect target captured in IND_CAP is used.
        if (opc_q == OP_BUN) begin
          pc_d     = ar_q;
          pc_out_d = ar_q;
        end else begin
          pc_out_d = pc_q;
        end
        ac_out_d  = ac_q;
        e_out_d   = e_q;
        done_d    = 1'b1;
        illegal_d = (opc_q == OP_REG);
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      opc_q     <= 3'd0;
      ar_q      <= {AW{1'b0}};
      ac_q      <= {DW{1'b0}};
      e_q       <= 1'b0;
      pc_q      <= {AW{1'b0}};
      dr_q      <= {DW{1'b0}};
      ac_out_q  <= {DW{1'b0}};
      e_out_q   <= 1'b0;
      pc_out_q  <= {AW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      ar_q      <= ar_d;
      ac_q      <= ac_d;
      e_q       <= e_d;
      pc_q      <= pc_d;
      dr_q      <= dr_d;
      ac_out_q  <= ac_out_d;
      e_out_q   <= e_out_d;
      pc_out_q  <= pc_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // SRAM port decoded from the state register; reset forces IDLE so the strobe drops at once.
  always_comb begin
    sram_addr  = {AW{1'b0}};
    sram_wdata = {DW{1'b0}};
    sram_we    = 1'b0;
    case (state_q)
      ST_IND_RD, ST_RD: sram_addr = ar_q;
      ST_WR: begin
        sram_addr = ar_q;
        sram_we   = 1'b1;
        case (opc_q)
          OP_STA:  sram_wdata = ac_q;
          OP_BSA:  sram_wdata = {{(DW-AW){1'b0}}, pc_q};
          OP_ISZ:  sram_wdata = dr_q;
          default: sram_wdata = {DW{1'b0}};
        endcase
      end
      default: sram_addr = {AW{1'b0}};
    endcase
  end

  assign ac_out  = ac_out_q;
  assign e_out   = e_out_q;
  assign pc_out  = pc_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mem_ref_exec.sv
// Directed self-checking bench for mem_ref_exec with a behavioural synchronous SRAM.
module tb_mem_ref_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic        ind = 1'b0;
  logic [11:0] ar_in = 12'd0;
  logic [15:0] ac_in = 16'd0;
  logic        e_in = 1'b0;
  logic [11:0] pc_in = 12'd0;
  logic [15:0] sram_rdata = 16'd0;
  logic [11:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we;
  logic [15:0] ac_out;
  logic        e_out;
  logic [11:0] pc_out;
  logic        busy, done, illegal;

  logic [15:0] mem [0:4095];
  int          wr_cnt = 0;
  logic [11:0] wr_addr = 12'd0;
  logic [15:0] wr_data = 16'd0;
  int          total = 0;
  int          bad = 0;
  int          lat;
  int          wr0;
  int          done_seen;

  mem_ref_exec dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ind(ind),
    .ar_in(ar_in), .ac_in(ac_in), .e_in(e_in), .pc_in(pc_in),
    .sram_rdata(sram_rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .ac_out(ac_out), .e_out(e_out), .pc_out(pc_out),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sram_rdata <= mem[sram_addr];
    if (sram_we) begin
      mem[sram_addr] <= sram_wdata;
      wr_cnt  = wr_cnt + 1;
      wr_addr = sram_addr;
      wr_data = sram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic ind_v, input logic [11:0] ar_v,
                     input logic [15:0] ac_v, input logic e_v, input logic [11:0] pc_v,
                     input int hold, output int l);
    int n;
    @(negedge clk);
    opcode = op; ind = ind_v; ar_in = ar_v; ac_in = ac_v; e_in = e_v; pc_in = pc_v;
    start = 1'b1;
    n = 0;
    l = -1;
    while (n < 20 && l < 0) begin
      @(negedge clk);
      n++;
      if (n >= hold) start = 1'b0;
      if (done) l = n - 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h010] = 16'h0001;
    mem[12'h011] = 16'h0F0F;
    mem[12'h020] = 16'h0030;
    mem[12'h030] = 16'hBEEF;
    mem[12'h040] = 16'hFFFF;
    mem[12'h070] = 16'h1111;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, sram_we}, 32'd0);
    chk("rst_outs", {3'd0, e_out, pc_out, ac_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ADD with carry out
    wr0 = wr_cnt;
    run(3'd1, 1'b0, 12'h010, 16'hFFFF, 1'b0, 12'h050, 1, lat);
    chk("add_lat", lat, 32'd3);
    chk("add_ac", {16'd0, ac_out}, 32'h0000);
    chk("add_e", {31'd0, e_out}, 32'd1);
    chk("add_pc", {20'd0, pc_out}, 32'h050);
    chk("add_nowr", wr_cnt - wr0, 32'd0);
    chk("add_illegal", {31'd0, illegal}, 32'd0);

    // LDA with ind set
    run(3'd2, 1'b1, 12'h020, 16'h1234, 1'b1, 12'h060, 1, lat);
`ifdef INDIRECT_EN
    chk("lda_lat", lat, 32'd5);
    chk("lda_ac", {16'd0, ac_out}, 32'hBEEF);
`else
    chk("lda_lat", lat, 32'd3);
    chk("lda_ac", {16'd0, ac_out}, 32'h0030);
`endif
    chk("lda_e", {31'd0, e_out}, 32'd1);

    // ISZ with skip
    wr0 = wr_cnt;
    run(3'd6, 1'b0, 12'h040, 16'h4321, 1'b0, 12'h105, 1, lat);
    chk("isz_lat", lat, 32'd4);
    chk("isz_wrcnt", wr_cnt - wr0, 32'd1);
    chk("isz_wr", {4'd0, wr_addr, wr_data}, 32'h0040_0000);
    chk("isz_pc", {20'd0, pc_out}, 32'h106);
    chk("isz_ac", {16'd0, ac_out}, 32'h4321);

    // ISZ without skip
    mem[12'h040] = 16'h0007;
    wr0 = wr_cnt;
    run(3'd6, 1'b0, 12'h040, 16'h4321, 1'b0, 12'h105, 1, lat);
    chk("isz2_wrcnt", wr_cnt - wr0, 32'd1);
    chk("isz2_mem", {16'd0, mem[12'h040]}, 32'h0008);
    chk("isz2_pc", {20'd0, pc_out}, 32'h105);

    // BSA at top of memory, pc wraps
    wr0 = wr_cnt;
    run(3'd5, 1'b0, 12'hFFF, 16'h0000, 1'b0, 12'h123, 1, lat);
    chk("bsa_lat", lat, 32'd2);
    chk("bsa_mem", {16'd0, mem[12'hFFF]}, 32'h0123);
    chk("bsa_pc", {20'd0, pc_out}, 32'h000);
    chk("bsa_wrcnt", wr_cnt - wr0, 32'd1);

    // AND
    run(3'd0, 1'b0, 12'h011, 16'h3C3C, 1'b1, 12'h010, 1, lat);
    chk("and_lat", lat, 32'd3);
    chk("and_ac", {16'd0, ac_out}, 32'h0C0C);
    chk("and_e", {31'd0, e_out}, 32'd1);

    // STA aborted by reset during the write cycle
    wr0 = wr_cnt;
    @(negedge clk);
    opcode = 3'd3; ind = 1'b0; ar_in = 12'h070; ac_in = 16'hA5A5; e_in = 1'b0; pc_in = 12'h080;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sta_we", {31'd0, sram_we}, 32'd1);
    chk("sta_wport", {4'd0, sram_addr, sram_wdata}, 32'h0070_A5A5);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_we", {31'd0, sram_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_nodone", done_seen, 32'd0);
    chk("abort_mem", {16'd0, mem[12'h070]}, 32'h1111);
    chk("abort_wrcnt", wr_cnt - wr0, 32'd0);
    rst = 1'b1;
    opcode = 3'd4; ar_in = 12'h200; ac_in = 16'h5555; e_in = 1'b1; pc_in = 12'h300;
    start = 1'b1;
    lat = -1;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) lat = n - 1;
    end
    chk("bun_lat", lat, 32'd1);
    chk("bun_pc", {20'd0, pc_out}, 32'h200);
    chk("bun_ac", {16'd0, ac_out}, 32'h5555);

    // Illegal opcode, start held a second cycle while busy
    wr0 = wr_cnt;
    run(3'd7, 1'b0, 12'h0AA, 16'h5555, 1'b1, 12'h200, 2, lat);
    chk("ill_lat", lat, 32'd1);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_outs", {3'd0, e_out, pc_out, ac_out}, 32'h1200_5555);
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("ill_second_ignored", done_seen, 32'd0);
    chk("ill_idle", {30'd0, busy, illegal}, 32'd0);
    chk("ill_nowr", wr_cnt - wr0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ref_exec.md
# mem_ref_exec

Memory-reference execution stage of the 16-bit basic computer. Sits directly downstream of the fetch/decode control (T0–T2). On a start pulse it takes the decoded opcode, I bit, AR, AC, E and PC, and executes AND, ADD, LDA, STA, BUN, BSA or ISZ against the shared SRAM. It returns updated AC/E/PC with a one-cycle done pulse.

## Interface
- AW, 12, address width (AR/PC)
- DW, 16, data width (AC/memory word)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- opcode  in  3  IR[14:12]
- ind  in  1  IR[15], indirect-address bit
- ar_in  in  AW  address field IR[11:0]
- ac_in / e_in / pc_in  in  DW / 1 / AW  current CPU state
- sram_rdata  in  DW  synchronous-read data, valid the cycle after the address is driven
- sram_addr  out  AW  memory address; meaningful only while busy
- sram_wdata  out  DW  write data
- sram_we  out  1  write strobe, one cycle
- ac_out / e_out / pc_out  out  DW / 1 / AW  result registers; valid when done=1
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- illegal  out  1  pulses with done when opcode=3'b111

## Operation
- Reset values: every output is 0; internal ac/e/pc/ar/dr are 0; the state is IDLE.
- IDLE, start=1: latch the inputs.
  - If ind=1 (and indirect is compiled in), go to IND_RD.
  - Otherwise, dispatch by opcode.
- IND_RD: drive sram_addr=ar. Next state is IND_CAP.
- IND_CAP: ar <= sram_rdata[11:0]. Then dispatch.
- Dispatch:
  - AND/ADD/LDA/ISZ → RD
  - STA/BSA → WR
  - BUN → DONE with pc=ar
  - 111 → DONE with illegal=1 and no state change
- RD: drive sram_addr=ar. Next state is EXEC.
- EXEC uses sram_rdata:
  - AND: ac &= rdata
  - ADD: {e,ac} = ac + rdata, 17-bit sum with carry into E
  - LDA: ac = rdata
  - ISZ: dr = rdata+1 (mod 2^16), then WR
- WR: sram_we=1 with sram_addr=ar.
  - STA: wdata=ac.
  - BSA: wdata={4'b0,pc}; pc <= ar+1 (mod 2^12).
  - ISZ: wdata=dr; if dr==0, pc <= pc+1 (mod 2^12).
- DONE: done=1 and busy=0 next cycle. Return to IDLE.
- start while busy is ignored and not queued.
- E is changed only by ADD. AC is changed only by AND/ADD/LDA.

## Timing
- Latency from the start cycle to the done cycle:
  - BUN/illegal: 1
  - STA/BSA: 2
  - AND/ADD/LDA: 3
  - ISZ: 4
  - Indirect adds +2 to each.
- sram_we is high for exactly one cycle per STA/BSA/ISZ and never otherwise.
- Outputs hold their values after done until the next start completes.
- Asynchronous reset mid-operation:
  - sram_we and busy drop immediately and the state becomes IDLE.
  - No partial write is completed.
  - A new start is accepted at the first clk edge after reset release.

## Configuration
- INDIRECT_EN defined: the ind bit is honoured and the IND_RD/IND_CAP states exist.
- INDIRECT_EN undefined: ind is ignored (every access is direct), the IND states are removed, and latencies are the direct values.

## Structure
- Shared package basic_cpu_pkg:
  - opcode constants OP_AND..OP_ISZ and OP_REG=3'b111
  - the state enum
  - AW/DW defaults
- One sub-module, mri_alu: combinational AND / 17-bit ADD / increment and zero-detect. It is used in EXEC and for the ISZ skip.

## Test plan
- ADD direct: ac=16'hFFFF, e=0, mem[0x010]=16'h0001 → after 3 cycles ac_out=0, e_out=1, no write.
- LDA indirect: mem[0x020]=16'h0030, mem[0x030]=16'hBEEF, ind=1 → ac_out=16'hBEEF after 5 cycles.
  - Without INDIRECT_EN, the same run loads mem[0x020].
- ISZ skip: mem[0x040]=16'hFFFF, pc=12'h105 → one write of 16'h0000 to 0x040, pc_out=12'h106.
  - The same run with mem=16'h0007 writes 16'h0008 and leaves pc=12'h105.
- BSA wrap: ar=12'hFFF, pc=12'h123 → mem[0xFFF]=16'h0123, pc_out=12'h000, done after 2 cycles.
- STA, then rst asserted in the WR cycle → sram_we falls immediately, busy=0, done never pulses, memory unchanged.
  - A later BUN to 0x200 gives pc_out=12'h200 after 1 cycle.
- opcode=111 with start, plus a second start while busy → illegal=1 with done, outputs unchanged, the second start is ignored.
